// File: rtl/psk_pulse_scheduler_if.sv
// Host-side control/status bundle for the PSK pulse scheduler.
// Carries start/stop, shadow config writes, hop table writes and status.
interface psk_pulse_scheduler_if #(
  parameter int CNT_W = 16,
  parameter int HOP_N = 4,
  parameter int F0_W  = 9
);
  localparam int AW = (HOP_N > 1) ? $clog2(HOP_N) : 1;

  logic             start;
  logic             stop;
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_pri;
  logic [CNT_W-1:0] cfg_width;
  logic [3:0]       cfg_mode;
  logic [5:0]       cfg_wave;
  logic             cfg_hop_en;
  logic             hop_we;
  logic [AW-1:0]    hop_waddr;
  logic [F0_W-1:0]  hop_wdata;
  logic             busy;
  logic             cfg_err;

  modport master (
    output start, stop, cfg_load,
    output cfg_pri, cfg_width, cfg_mode,
    output cfg_wave, cfg_hop_en,
    output hop_we, hop_waddr, hop_wdata,
    input  busy, cfg_err
  );

  modport slave (
    input  start, stop, cfg_load,
    input  cfg_pri, cfg_width, cfg_mode,
    input  cfg_wave, cfg_hop_en,
    input  hop_we, hop_waddr, hop_wdata,
    output busy, cfg_err
  );
endinterface

// File: rtl/psk_pulse_scheduler.sv
// PRI/duty gate, carrier hop and config-apply sequencer
// feeding the m-sequence BPSK/QPSK phase datapath.
module psk_pulse_scheduler #(
  parameter int CNT_W = 16,
  parameter int HOP_N = 4,
  parameter int F0_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psk_pulse_scheduler_if.slave host,
  output logic [F0_W-1:0]      F0,
  output logic                 FW_flag,
  output logic                 judge,
  output logic                 T_cnt,
  output logic [3:0]           mode_sel,
  output logic [5:0]           wave_sel
);
  localparam int AW = (HOP_N > 1) ? $clog2(HOP_N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_OFF   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sh_pri, sh_width;
  logic [3:0]       sh_mode;
  logic [5:0]       sh_wave;
  logic             sh_hop_en;
  logic [CNT_W-1:0] act_pri, act_width;
  logic             act_cont, act_hop_en;
  logic             pend;
  logic [F0_W-1:0]  tbl [HOP_N];
  logic [AW-1:0]    idx, nidx;
  logic             sh_ok, last_on, last_pri, do_apply;

  always_comb begin
    sh_ok = (tbl[0] != '0) && (sh_pri != '0);
    if (sh_mode != 4'b0001)
      sh_ok = sh_ok && (sh_width != '0) &&
              (sh_width < sh_pri);
    nidx = idx + AW'(1);
    last_pri = ((state == S_ON && act_cont) ||
                state == S_OFF) &&
               (cnt == act_pri - CNT_W'(1));
    last_on = (state == S_ON) && !act_cont &&
              (cnt == act_width - CNT_W'(1));
    do_apply = !host.stop && sh_ok &&
               ((state == S_IDLE && host.start) ||
                (last_pri && pend));
  end

  // Writes land at the edge, so a same-cycle boundary read sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HOP_N; i++)
        tbl[i] <= F0_W'(1);
    end else if (host.hop_we) begin
      tbl[host.hop_waddr] <= host.hop_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sh_pri       <= '0;
      sh_width     <= '0;
      sh_mode      <= '0;
      sh_wave      <= '0;
      sh_hop_en    <= 1'b0;
      act_pri      <= '0;
      act_width    <= '0;
      act_cont     <= 1'b0;
      act_hop_en   <= 1'b0;
      pend         <= 1'b0;
      idx          <= '0;
      F0           <= F0_W'(1);
      FW_flag      <= 1'b0;
      judge        <= 1'b0;
      T_cnt        <= 1'b1;
      mode_sel     <= 4'b0001;
      wave_sel     <= '0;
      host.busy    <= 1'b0;
      host.cfg_err <= 1'b0;
    end else begin
      judge   <= 1'b0;
      FW_flag <= 1'b0;
      if (host.stop) begin
        state     <= S_IDLE;
        T_cnt     <= 1'b1;
        host.busy <= 1'b0;
        pend      <= 1'b0;
      end else if (do_apply) begin
        state        <= S_APPLY;
        judge        <= 1'b1;
        host.busy    <= 1'b1;
        host.cfg_err <= 1'b0;
        pend         <= 1'b0;
        T_cnt        <= 1'b1;
        mode_sel     <= sh_mode;
        wave_sel     <= sh_wave;
        F0           <= tbl[0];
        idx          <= '0;
        act_pri      <= sh_pri;
        act_width    <= sh_width;
        act_cont     <= (sh_mode == 4'b0001);
        act_hop_en   <= sh_hop_en;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (host.start) host.cfg_err <= 1'b1;
          end
          S_APPLY: begin
            state <= S_ON;
            cnt   <= '0;
            T_cnt <= 1'b0;
          end
          S_ON, S_OFF: begin
            cnt <= cnt + CNT_W'(1);
            if (last_pri) begin
              state <= S_ON;
              cnt   <= '0;
              T_cnt <= 1'b0;
              if (pend) begin
                host.cfg_err <= 1'b1;
                pend         <= 1'b0;
              end else if (act_hop_en) begin
                idx <= nidx;
                if (tbl[nidx] != '0) begin
                  F0      <= tbl[nidx];
                  FW_flag <= 1'b1;
                end
              end
            end else if (last_on) begin
              state <= S_OFF;
              T_cnt <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      // A load landing on a boundary stays pending for the next PRI.
      if (host.cfg_load) begin
        sh_pri    <= host.cfg_pri;
        sh_width  <= host.cfg_width;
        sh_mode   <= host.cfg_mode;
        sh_wave   <= host.cfg_wave;
        sh_hop_en <= host.cfg_hop_en;
        if (state != S_IDLE && !host.stop)
          pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_psk_pulse_scheduler.sv
// Directed self-checking bench for psk_pulse_scheduler.
// Hand-computed expectations for gate, hop, apply and stop timing.
module tb_psk_pulse_scheduler;
  localparam int CNT_W = 16;
  localparam int HOP_N = 4;
  localparam int F0_W  = 9;

  logic            clk;
  logic            rst_n;
  logic [F0_W-1:0] F0;
  logic            FW_flag, judge, T_cnt;
  logic [3:0]      mode_sel;
  logic [5:0]      wave_sel;
  int              n_chk;
  int              n_err;

  psk_pulse_scheduler_if #(
    .CNT_W(CNT_W), .HOP_N(HOP_N), .F0_W(F0_W)
  ) hif ();

  psk_pulse_scheduler #(
    .CNT_W(CNT_W), .HOP_N(HOP_N), .F0_W(F0_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(hif.slave),
    .F0(F0),
    .FW_flag(FW_flag),
    .judge(judge),
    .T_cnt(T_cnt),
    .mode_sel(mode_sel),
    .wave_sel(wave_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int pri, input int width,
                         input int mode, input int wave,
                         input bit hop);
    hif.cfg_pri    = CNT_W'(pri);
    hif.cfg_width  = CNT_W'(width);
    hif.cfg_mode   = 4'(mode);
    hif.cfg_wave   = 6'(wave);
    hif.cfg_hop_en = hop;
  endtask

  task automatic load_cfg(input int pri, input int width,
                          input int mode, input int wave,
                          input bit hop);
    set_cfg(pri, width, mode, wave, hop);
    hif.cfg_load = 1'b1;
    tick();
    hif.cfg_load = 1'b0;
  endtask

  task automatic hop_wr(input int a, input int d);
    hif.hop_we    = 1'b1;
    hif.hop_waddr = 2'(a);
    hif.hop_wdata = F0_W'(d);
    tick();
    hif.hop_we = 1'b0;
  endtask

  task automatic do_start;
    hif.start = 1'b1;
    tick();
    hif.start = 1'b0;
  endtask

  task automatic do_stop;
    hif.stop = 1'b1;
    tick();
    hif.stop = 1'b0;
  endtask

  int seq [5];
  int expf;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    hif.start = 0; hif.stop = 0; hif.cfg_load = 0;
    hif.hop_we = 0; hif.hop_waddr = 0; hif.hop_wdata = 0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_F0", F0, 1);
    chk("rst_T_cnt", T_cnt, 1);
    chk("rst_mode", mode_sel, 4'b0001);
    chk("rst_wave", wave_sel, 0);
    chk("rst_busy", hif.busy, 0);
    chk("rst_err", hif.cfg_err, 0);
    chk("rst_judge", judge, 0);
    chk("rst_fw", FW_flag, 0);
    rst_n = 1'b1;
    tick();

    // invalid configs, then a valid one
    do_start();
    chk("zero_cfg_err", hif.cfg_err, 1);
    load_cfg(10, 10, 2, 0, 0);
    do_start();
    chk("w_eq_pri_err", hif.cfg_err, 1);
    chk("w_eq_pri_busy", hif.busy, 0);
    chk("w_eq_pri_judge", judge, 0);
    load_cfg(10, 4, 2, 0, 0);
    do_start();
    chk("fix_err", hif.cfg_err, 0);
    chk("fix_busy", hif.busy, 1);
    chk("fix_judge", judge, 1);
    do_stop();
    chk("fix_stop_busy", hif.busy, 0);

    // pulsed gate pattern
    load_cfg(10, 3, 2, 5, 0);
    do_start();
    chk("p_judge", judge, 1);
    chk("p_mode", mode_sel, 2);
    chk("p_wave", wave_sel, 5);
    chk("p_F0", F0, 1);
    chk("p_apply_T", T_cnt, 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("p_T_cnt", T_cnt, (i % 10 < 3) ? 0 : 1);
      chk("p_judge_lo", judge, 0);
      chk("p_fw_lo", FW_flag, 0);
    end
    do_stop();
    chk("stop_T", T_cnt, 1);
    chk("stop_busy", hif.busy, 0);
    chk("stop_mode_hold", mode_sel, 2);

    // stop mid-ON, then start+stop collision
    do_start();
    repeat (3) tick();
    chk("mid_on_T", T_cnt, 0);
    do_stop();
    chk("mid_stop_T", T_cnt, 1);
    chk("mid_stop_busy", hif.busy, 0);
    hif.start = 1'b1;
    hif.stop  = 1'b1;
    tick();
    hif.start = 1'b0;
    hif.stop  = 1'b0;
    chk("ss_judge", judge, 0);
    chk("ss_busy", hif.busy, 0);
    tick();
    chk("ss_busy2", hif.busy, 0);
    chk("ss_judge2", judge, 0);

    // hop sequence with wrap
    hop_wr(0, 50);
    hop_wr(1, 100);
    hop_wr(2, 200);
    hop_wr(3, 25);
    load_cfg(8, 3, 2, 7, 1);
    do_start();
    chk("h_judge", judge, 1);
    chk("h_F0_apply", F0, 50);
    chk("h_fw_apply", FW_flag, 0);
    seq = '{50, 100, 200, 25, 50};
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("h_F0", F0, seq[k]);
        chk("h_fw", FW_flag, (k > 0 && c == 0) ? 1 : 0);
      end
    end

    // deferred reconfig applied at the PRI boundary
    for (int c = 0; c < 8; c++) begin
      tick();
      hif.cfg_load = 1'b0;
      chk("d_wave_hold", wave_sel, 7);
      chk("d_judge_lo", judge, 0);
      if (c == 2) begin
        set_cfg(8, 3, 2, 6'b010000, 1);
        hif.cfg_load = 1'b1;
      end
    end
    tick();
    chk("d_judge", judge, 1);
    chk("d_wave", wave_sel, 6'b010000);
    chk("d_F0", F0, 50);
    chk("d_fw", FW_flag, 0);
    tick();
    chk("d_T_on", T_cnt, 0);
    chk("d_judge_lo2", judge, 0);

    // async reset while transmitting
    tick();
    chk("r_pre_busy", hif.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_T", T_cnt, 1);
    chk("r_busy", hif.busy, 0);
    chk("r_F0", F0, 1);
    chk("r_mode", mode_sel, 4'b0001);
    chk("r_fw", FW_flag, 0);
    tick();
    chk("r_T2", T_cnt, 1);
    rst_n = 1'b1;
    tick();

    // continuous mode, zero hop entry is skipped
    hop_wr(1, 0);
    hop_wr(2, 77);
    load_cfg(4, 2, 1, 0, 1);
    do_start();
    chk("c_judge", judge, 1);
    chk("c_F0", F0, 1);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expf = (k < 2) ? 1 : 77;
        chk("c_T", T_cnt, 0);
        chk("c_F0_run", F0, expf);
        chk("c_fw", FW_flag, (k == 2 && c == 0) ? 1 : 0);
      end
    end
    do_stop();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
